// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and helpers for the instruction prefetch buffer
package fetch_pkg;

    localparam logic [1:0] OPC_UNCOMPRESSED = 2'b11;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } fifo_entry_t;

    function automatic logic is_compressed(input logic [1:0] opc);
        return opc != OPC_UNCOMPRESSED;
    endfunction

endpackage

// File: rtl/fetch_prefetch_buffer_if.sv
// rtl/fetch_prefetch_buffer_if.sv - OBI-style instruction fetch bus (req/gnt/rvalid)
interface fetch_prefetch_buffer_if;
    logic        instr_req_o;
    logic        instr_gnt_i;
    logic [31:0] instr_addr_o;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;
    logic        instr_rvalid_i;

    modport master (
        output instr_req_o, instr_addr_o,
        input  instr_gnt_i, instr_rdata_i, instr_err_i, instr_rvalid_i
    );

    modport slave (
        input  instr_req_o, instr_addr_o,
        output instr_gnt_i, instr_rdata_i, instr_err_i, instr_rvalid_i
    );
endinterface

// File: rtl/fetch_prefetch_buffer_fifo.sv
// rtl/fetch_prefetch_buffer_fifo.sv - shift-down word FIFO with entry0/entry1 views
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int FW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clear,
    input  logic          push,
    input  fifo_entry_t   push_entry,
    input  logic          pop,
    output fifo_entry_t   entry0,
    output fifo_entry_t   entry1,
    output logic [FW-1:0] count
);

    fifo_entry_t   entries_q [DEPTH];
    fifo_entry_t   entries_d [DEPTH];
    logic [FW-1:0] count_q;
    logic [FW-1:0] count_d;

    // Pop shifts first so a push into a full FIFO lands in the freed slot.
    always_comb begin
        entries_d = entries_q;
        count_d   = count_q;
        if (clear) begin
            count_d = '0;
        end else begin
            if (pop && count_q != '0) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    entries_d[i] = entries_q[i+1];
                end
                count_d = count_q - FW'(1);
            end
            if (push && count_d < FW'(DEPTH)) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (FW'(i) == count_d) begin
                        entries_d[i] = push_entry;
                    end
                end
                count_d = count_d + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
        end
    end

    assign entry0 = entries_q[0];
    assign entry1 = entries_q[1];
    assign count  = count_q;

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// rtl/fetch_prefetch_buffer.sv - prefetch buffer: request control, discard on redirect, RVC aligner
module fetch_prefetch_buffer
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          NUM_REQS = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    fetch_prefetch_buffer_if.master  bus,
    input  logic                     redirect_i,
    input  logic [31:0]              redirect_pc_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [31:0]              out_instr_o,
    output logic [31:0]              out_pc_o,
    output logic                     out_compressed_o,
    output logic                     out_err_o,
    output logic                     busy_o
);

    localparam int FW = $clog2(DEPTH + 1);
    localparam int CW = FW + 1;

    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic          stale_q, stale_d;
    logic [31:0]   stale_addr_q, stale_addr_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [31:0]   pc_q, pc_d;

    fifo_entry_t   e0, e1, push_entry;
    logic [FW-1:0] fifo_count;
    logic          fifo_push, fifo_pop;

    logic          grant, new_grant, rsp_discard, rsp_keep, accept;
    logic          valid0, valid1, comp, pop_word, align_valid, align_err;
    logic [15:0]   half;
    logic [31:0]   align_instr, unaligned_word;
    logic [CW-1:0] occ_next;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (redirect_i),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .entry0     (e0),
        .entry1     (e1),
        .count      (fifo_count)
    );

    // Aligner: an error word is treated as 32-bit so the PC still advances by 4.
    always_comb begin
        valid0         = fifo_count != '0;
        valid1         = fifo_count > FW'(1);
        half           = pc_q[1] ? e0.data[31:16] : e0.data[15:0];
        unaligned_word = 32'({e1.data, e0.data} >> 16);
        comp           = is_compressed(half[1:0]) & ~e0.err;
        align_instr    = e0.data;
        align_valid    = valid0;
        align_err      = e0.err;
        pop_word       = 1'b1;
        if (comp) begin
            align_instr = {16'h0000, half};
            pop_word    = pc_q[1];
        end else if (pc_q[1]) begin
            align_instr = unaligned_word;
            align_valid = valid1;
            align_err   = e0.err | e1.err;
        end
    end

    always_comb begin
        grant       = req_q & bus.instr_gnt_i;
        new_grant   = grant & ~stale_q;
        rsp_discard = bus.instr_rvalid_i & (discard_q != '0);
        rsp_keep    = bus.instr_rvalid_i & (discard_q == '0) & (outstanding_q != '0);
        accept      = align_valid & out_ready_i & ~redirect_i;
        fifo_push   = rsp_keep & ~redirect_i;
        fifo_pop    = accept & pop_word;
        push_entry  = '{err: bus.instr_err_i, data: bus.instr_rdata_i};

        outstanding_d = outstanding_q + CW'(new_grant) - CW'(rsp_keep);
        discard_d     = discard_q - CW'(rsp_discard);
        addr_d        = addr_q;
        stale_d       = stale_q;
        stale_addr_d  = stale_addr_q;
        pc_d          = pc_q;

        if (grant) begin
            addr_d  = stale_q ? stale_addr_q : addr_q + 32'd4;
            stale_d = 1'b0;
        end
        if (accept) begin
            pc_d = pc_q + (comp ? 32'd2 : 32'd4);
        end
        // A still-pending request must finish at its old address; its response is junk.
        if (redirect_i) begin
            discard_d     = discard_d + outstanding_d;
            outstanding_d = '0;
            pc_d          = redirect_pc_i & 32'hFFFF_FFFE;
            if (req_q && !bus.instr_gnt_i) begin
                if (!stale_q) begin
                    discard_d = discard_d + CW'(1);
                end
                stale_d      = 1'b1;
                stale_addr_d = redirect_pc_i & 32'hFFFF_FFFC;
            end else begin
                addr_d = redirect_pc_i & 32'hFFFF_FFFC;
            end
        end

        occ_next = redirect_i ? '0 : CW'(fifo_count) + CW'(fifo_push) - CW'(fifo_pop);
        if (req_q && !bus.instr_gnt_i) begin
            req_d = 1'b1;
        end else begin
            req_d = ((occ_next + outstanding_d + discard_d) < CW'(DEPTH))
                 && ((outstanding_d + discard_d) < CW'(NUM_REQS));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_q         <= 1'b0;
            addr_q        <= PC_RESET & 32'hFFFF_FFFC;
            stale_q       <= 1'b0;
            stale_addr_q  <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            pc_q          <= PC_RESET;
        end else begin
            req_q         <= req_d;
            addr_q        <= addr_d;
            stale_q       <= stale_d;
            stale_addr_q  <= stale_addr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            pc_q          <= pc_d;
        end
    end

    assign bus.instr_req_o  = req_q;
    assign bus.instr_addr_o = addr_q;
    assign out_valid_o      = align_valid;
    assign out_instr_o      = align_instr;
    assign out_pc_o         = pc_q;
    assign out_compressed_o = comp;
    assign out_err_o        = align_err;
    assign busy_o           = (outstanding_q != '0) || (discard_q != '0);

    rvalid_expected_a: assert property (@(posedge clk) disable iff (!rstn)
        bus.instr_rvalid_i |-> (outstanding_q != '0) || (discard_q != '0));

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// tb/tb_fetch_prefetch_buffer.sv - randomized bench against a halfword-level fetch model
module tb_fetch_prefetch_buffer;

    localparam logic [31:0] PC_RESET = 32'h0000_0100;
    localparam int          DEPTH    = 4;
    localparam int          NUM_REQS = 2;
    localparam int          CYCLES   = 6000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        out_valid_o, out_ready_i, out_compressed_o, out_err_o, busy_o;
    logic [31:0] out_instr_o, out_pc_o;

    fetch_prefetch_buffer_if bus ();

    fetch_prefetch_buffer #(
        .PC_RESET (PC_RESET),
        .DEPTH    (DEPTH),
        .NUM_REQS (NUM_REQS)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .bus              (bus),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_instr_o      (out_instr_o),
        .out_pc_o         (out_pc_o),
        .out_compressed_o (out_compressed_o),
        .out_err_o        (out_err_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] mem     [256];
    logic        mem_err [256];

    function automatic logic [15:0] half_at(input logic [31:0] pc);
        logic [31:0] w;
        w = mem[pc[9:2]];
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    // Reference: decode the instruction at pc straight from the memory image.
    task automatic ref_instr(input logic [31:0] pc, output logic [31:0] instr,
                             output logic comp, output logic err, output logic [31:0] len);
        logic [15:0] lo;
        logic        e0;
        lo    = half_at(pc);
        e0    = mem_err[pc[9:2]];
        comp  = !e0 && (lo[1:0] != 2'b11);
        err   = e0;
        if (!comp && pc[1]) err = e0 | mem_err[8'(pc[9:2] + 8'd1)];
        instr = comp ? {16'h0000, lo} : {half_at(pc + 32'd2), lo};
        len   = comp ? 32'd2 : 32'd4;
    endtask

    logic [31:0] rsp_addr_q [$];
    int          rsp_due_q  [$];

    logic [31:0] model_pc, exp_addr, stale_tgt, prev_addr;
    logic        stale, prev_pending, prev_redirect;
    logic [31:0] e_instr, e_len;
    logic        e_comp, e_err;
    int          n_accept;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            if ($urandom_range(0, 1) == 1) mem[i][1:0] = 2'b11;
            if ($urandom_range(0, 1) == 1) mem[i][17:16] = 2'b11;
            mem_err[i] = ($urandom_range(0, 15) == 0);
        end

        rstn               = 1'b0;
        bus.instr_gnt_i    = 1'b0;
        bus.instr_rvalid_i = 1'b0;
        bus.instr_rdata_i  = '0;
        bus.instr_err_i    = 1'b0;
        redirect_i         = 1'b1;
        redirect_pc_i      = 32'h0000_0300;
        out_ready_i        = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_req", bus.instr_req_o, 0);
        check_eq("rst_addr", bus.instr_addr_o, PC_RESET & 32'hFFFF_FFFC);
        check_eq("rst_valid", out_valid_o, 0);
        check_eq("rst_pc", out_pc_o, PC_RESET);
        check_eq("rst_instr", out_instr_o, 0);
        check_eq("rst_err", out_err_o, 0);
        check_eq("rst_busy", busy_o, 0);

        rstn       = 1'b1;
        redirect_i = 1'b0;
        @(negedge clk);
        check_eq("req_after_rst", bus.instr_req_o, 1);
        check_eq("addr_after_rst", bus.instr_addr_o, PC_RESET);
        check_eq("pc_after_rst", out_pc_o, PC_RESET);

        model_pc      = PC_RESET;
        exp_addr      = PC_RESET;
        stale         = 1'b0;
        stale_tgt     = '0;
        prev_pending  = 1'b0;
        prev_redirect = 1'b0;
        prev_addr     = '0;
        n_accept      = 0;

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (prev_pending) begin
                check_eq("req_hold", bus.instr_req_o, 1);
                check_eq("addr_hold", bus.instr_addr_o, prev_addr);
            end
            if (prev_redirect) check_eq("valid_after_redirect", out_valid_o, 0);
            check_eq("inflight_limit", 32'(rsp_addr_q.size() <= NUM_REQS), 1);

            bus.instr_gnt_i = (cyc < 40 || cyc >= CYCLES - 30) ? (cyc < CYCLES - 30)
                                                               : ($urandom_range(0, 3) != 0);
            out_ready_i     = (cyc < 40) ? 1'b1 : (cyc % 500 >= 100 && cyc % 500 < 110) ? 1'b0
                                                                    : ($urandom_range(0, 3) != 0);
            redirect_i      = (cyc >= 40 && cyc < CYCLES - 60) && ($urandom_range(0, 49) == 0);
            redirect_pc_i   = 32'($urandom_range(0, 1023));

            bus.instr_rvalid_i = 1'b0;
            bus.instr_rdata_i  = $urandom;
            bus.instr_err_i    = $urandom_range(0, 1) == 1;
            if (rsp_addr_q.size() != 0 && rsp_due_q[0] <= cyc
                && (cyc < 40 || $urandom_range(0, 3) != 0)) begin
                bus.instr_rvalid_i = 1'b1;
                bus.instr_rdata_i  = mem[rsp_addr_q[0][9:2]];
                bus.instr_err_i    = mem_err[rsp_addr_q[0][9:2]];
                void'(rsp_addr_q.pop_front());
                void'(rsp_due_q.pop_front());
            end

            if (bus.instr_req_o && bus.instr_gnt_i) begin
                check_eq("fetch_addr", bus.instr_addr_o, exp_addr);
                rsp_addr_q.push_back(bus.instr_addr_o);
                rsp_due_q.push_back(cyc + ((cyc < 40) ? 1 : $urandom_range(1, 4)));
                exp_addr = stale ? stale_tgt : exp_addr + 32'd4;
                stale    = 1'b0;
            end

            if (redirect_i) begin
                if (bus.instr_req_o && !bus.instr_gnt_i) begin
                    stale     = 1'b1;
                    stale_tgt = redirect_pc_i & 32'hFFFF_FFFC;
                end else begin
                    exp_addr = redirect_pc_i & 32'hFFFF_FFFC;
                end
                model_pc = redirect_pc_i & 32'hFFFF_FFFE;
            end else if (out_valid_o && out_ready_i) begin
                ref_instr(model_pc, e_instr, e_comp, e_err, e_len);
                check_eq("out_pc", out_pc_o, model_pc);
                check_eq("out_err", out_err_o, e_err);
                check_eq("out_compressed", out_compressed_o, e_comp);
                if (!e_err) check_eq("out_instr", out_instr_o, e_instr);
                model_pc = model_pc + e_len;
                n_accept++;
            end

            prev_pending  = bus.instr_req_o && !bus.instr_gnt_i;
            prev_addr     = bus.instr_addr_o;
            prev_redirect = redirect_i;
        end

        @(negedge clk);
        check_eq("drain_rsp_queue", rsp_addr_q.size(), 0);
        check_eq("drain_busy", busy_o, 0);
        check_eq("progress", 32'(n_accept >= 300), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_buffer.md
Name: fetch_prefetch_buffer

Overview:
- Parametrised instruction prefetch stage with multiple outstanding fetches.
- Issues word-aligned fetches on an OBI-style req/gnt/rvalid bus and buffers returned words in a DEPTH-entry FIFO.
- Realigns 16/32-bit (RVC) instructions and delivers them, with PC and error flag, to decode over a valid/ready handshake.
- Handles redirects (branch/trap) by flushing the FIFO and discarding in-flight responses; sits between the instruction memory port and decode.

Parameters:
- PC_RESET, 32'h0000_0000, first fetch/PC after reset (bit0 must be 0)
- DEPTH, 4, FIFO entries (32-bit words), min 2
- NUM_REQS, 2, max outstanding bus requests (granted, rvalid not yet seen), min 1, NUM_REQS <= DEPTH

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- instr_req_o  out  1  bus request
- instr_gnt_i  in  1  bus grant; request accepted when req&gnt
- instr_addr_o  out  32  fetch address, [1:0]=0
- instr_rdata_i  in  32  response data
- instr_err_i  in  1  response error, qualified by rvalid
- instr_rvalid_i  in  1  response valid, in request order
- redirect_i  in  1  PC change (branch/jump/trap), single cycle
- redirect_pc_i  in  32  new PC, bit0 ignored
- out_valid_o  out  1  instruction available
- out_ready_i  in  1  decode accepts (stall = !out_ready_i)
- out_instr_o  out  32  instruction; compressed: [15:0] valid, [31:16] zero
- out_pc_o  out  32  PC of out_instr_o
- out_compressed_o  out  1  out_instr_o[1:0] != 2'b11
- out_err_o  out  1  fetch error on any word of this instruction
- busy_o  out  1  outstanding != 0

Behaviour:
- Reset: instr_req_o=0, instr_addr_o=PC_RESET&~3, out_valid_o=0, out_pc_o=PC_RESET, out_instr_o=0, out_err_o=0, busy_o=0; FIFO empty, counters 0. instr_req_o rises the first cycle after reset release.
- Request rule: instr_req_o=1 when occupied + outstanding < DEPTH and outstanding < NUM_REQS. Once raised, instr_req_o and instr_addr_o hold until gnt. On req&gnt: outstanding+1, instr_addr_o += 4.
- Response: rvalid pushes {err, rdata} to FIFO tail and decrements outstanding. Simultaneous gnt and rvalid leaves outstanding unchanged. rvalid with outstanding==0 is a protocol error; covered by an assertion and otherwise ignored.
- Output is purely from FIFO registers; latency rvalid -> out_valid_o = 1 cycle.
- Aligner, pc[1]=0: word0 selected. Compressed if [1:0]!=11. Valid when entry0 occupied.
- Aligner, pc[1]=1: halfword word0[31:16]. If compressed, valid with entry0 only. Otherwise {word1[15:0], word0[31:16]}, valid only when entry1 is also occupied; out_err_o = err0|err1.
- Accept (out_valid_o & out_ready_i): out_pc_o += 2 (compressed) or 4. Word0 popped when the consumed instruction ends at or beyond word0[31:16] (aligned 32-bit, or unaligned any). Aligned compressed does not pop. Entries shift down one per pop; push and pop in the same cycle are allowed when full.
- Error: out_err_o=1 means out_instr_o is undefined; the aligner still assumes 32-bit length for PC increment.
- Redirect (highest priority, overrides same-cycle accept):
  - FIFO cleared next cycle.
  - discard_cnt = outstanding (plus 1 if this cycle's req&gnt; minus 1 if this cycle's rvalid).
  - out_pc_o = redirect_pc_i.
  - Next fetch address = redirect_pc_i & ~3. A pending un-granted request completes at its old address and is added to discard_cnt.
  - out_valid_o=0 the cycle after redirect.
- Discard: while discard_cnt>0, rvalid decrements discard_cnt and is not pushed. The request limit counts discard_cnt as outstanding.
- Redirect to an odd-halfword target: the first word's low half is dropped by the aligner (pc[1]=1).
- A redirect during reset has no effect.

Decomposition:
- Package fetch_pkg:
  - typedef fifo_entry_t {logic err; logic [31:0] data;}
  - function is_compressed(logic [1:0])
  - constant OPC_UNCOMPRESSED=2'b11
- Sub-module fetch_fifo (DEPTH parameter; push/pop/clear, entry0/entry1 views, occupancy count). Request control, discard counter and aligner stay in the top.

Test Plan:
- Reset with PC_RESET=32'h100, memory of 32-bit instrs, gnt=1, rvalid 1 cycle later -> addresses 100,104,108...; out_pc_o 100,104... one per cycle with out_ready_i=1.
- Word 32'h0001_4501 at 0x0 (two compressed) -> out_pc_o 0 (instr 16'h4501), then 2 (16'h0001); single pop.
- Compressed at 0x0, 32-bit 0x0000_0513 split across words at 0x2 -> second output pc=2, instr 32'h0000_0513, valid only after the word at 0x4 has arrived.
- NUM_REQS=2, gnt every cycle, rvalid delayed 3 cycles, redirect to 0x202 with 2 outstanding -> 2 responses dropped, next req addr 0x200, first out_pc_o=0x202.
- out_ready_i=0 for 10 cycles -> requests stop when occupied+outstanding=DEPTH; no data lost; resume in order.
- instr_err_i=1 on the word at 0x8 -> instruction at pc 8 (and an unaligned one at 0x6 spanning it) has out_err_o=1; others 0.
